// File: rtl/operand_stim_gen.sv
// Operand stimulus sequencer: drives a/b operands through A_ONLY -> B_ONLY -> A_AND_B phases
// using two xorshift32 generators, with a valid/ready handshake and a fixed vector count per run.
module operand_stim_gen #(
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED_A      = 32'd1,
    parameter logic [31:0] SEED_B      = 32'd2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ready,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic                 valid,
    output logic [1:0]           phase,
    output logic [15:0]          count,
    output logic                 done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_A_ONLY  = 3'd1;
    localparam logic [2:0] S_B_ONLY  = 3'd2;
    localparam logic [2:0] S_A_AND_B = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [1:0] PH_A_ONLY  = 2'b00;
    localparam logic [1:0] PH_B_ONLY  = 2'b01;
    localparam logic [1:0] PH_A_AND_B = 2'b10;

    localparam logic [15:0] LAST_COUNT = 16'(NUM_VECTORS);

    logic [2:0]           state, state_nxt;
    logic [31:0]          prng_a, prng_a_nxt;
    logic [31:0]          prng_b, prng_b_nxt;
    logic [DATAWIDTH-1:0] a_nxt, b_nxt;
    logic                 valid_nxt;
    logic [1:0]           phase_nxt;
    logic [15:0]          count_nxt;
    logic                 done_nxt;
    logic [31:0]          xs_a, xs_b;
    logic [15:0]          count_inc;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    assign xs_a      = xorshift32(prng_a);
    assign xs_b      = xorshift32(prng_b);
    assign count_inc = count + 16'd1;

    // State and output registers; everything visible on the ports is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            prng_a <= SEED_A;
            prng_b <= SEED_B;
            a      <= '0;
            b      <= '0;
            valid  <= 1'b0;
            phase  <= PH_A_ONLY;
            count  <= 16'd0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            prng_a <= prng_a_nxt;
            prng_b <= prng_b_nxt;
            a      <= a_nxt;
            b      <= b_nxt;
            valid  <= valid_nxt;
            phase  <= phase_nxt;
            count  <= count_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state and next-output logic; a generator steps only when its operand is reloaded.
    always_comb begin
        state_nxt  = state;
        prng_a_nxt = prng_a;
        prng_b_nxt = prng_b;
        a_nxt      = a;
        b_nxt      = b;
        valid_nxt  = valid;
        phase_nxt  = phase;
        count_nxt  = count;
        done_nxt   = done;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_A_ONLY;
                    prng_a_nxt = xs_a;
                    a_nxt      = xs_a[DATAWIDTH-1:0];
                    b_nxt      = '0;
                    valid_nxt  = 1'b1;
                    phase_nxt  = PH_A_ONLY;
                end
            end
            S_A_ONLY, S_B_ONLY, S_A_AND_B: begin
                if (ready) begin
                    count_nxt = count_inc;
                    if (count_inc == LAST_COUNT) begin
                        state_nxt = S_DONE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else if (state == S_A_ONLY) begin
                        state_nxt  = S_B_ONLY;
                        prng_b_nxt = xs_b;
                        b_nxt      = xs_b[DATAWIDTH-1:0];
                        phase_nxt  = PH_B_ONLY;
                    end else begin
                        state_nxt  = S_A_AND_B;
                        prng_a_nxt = xs_a;
                        prng_b_nxt = xs_b;
                        a_nxt      = xs_a[DATAWIDTH-1:0];
                        b_nxt      = xs_b[DATAWIDTH-1:0];
                        phase_nxt  = PH_A_AND_B;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
